// File: rtl/enable_register.sv
// enable_register: N-bit holding register with synchronous load enable and
// asynchronous active-low reset. Basic storage stage of the CDC synchronizer
// datapath: captures D on a rising clk edge when enabled, otherwise holds.
module enable_register #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q
);

    // Stored word: cleared asynchronously while reset is low, loaded from D on enabled edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Q <= '0;
        end else if (enable) begin
            Q <= D;
        end
    end

endmodule

// File: tb/tb_enable_register.sv
// tb_enable_register: table-driven and randomized checks of enable_register
// at widths 1, 8 and 16, sharing clk/reset/enable across the three instances.
module tb_enable_register;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [0:0]  d1;
    logic [7:0]  d8;
    logic [15:0] d16;
    logic [0:0]  q1;
    logic [7:0]  q8;
    logic [15:0] q16;

    int unsigned vectors;
    int unsigned miscompares;

    // reference model: value each register should hold, from the load/hold/reset rules
    logic [0:0]  m1;
    logic [7:0]  m8;
    logic [15:0] m16;

    enable_register #(.N(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .D(d1), .Q(q1)
    );
    enable_register #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .enable(enable), .D(d8), .Q(q8)
    );
    enable_register #(.N(16)) dut16 (
        .clk(clk), .reset(reset), .enable(enable), .D(d16), .Q(q16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] d;
        logic [7:0] exp_q;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name);
        check({name, "/n1"},  {15'd0, q1}, {15'd0, m1});
        check({name, "/n8"},  {8'd0, q8},  {8'd0, m8});
        check({name, "/n16"}, q16,         m16);
    endtask

    // drive inputs at the falling edge, advance past the rising edge, update the model
    task automatic step(input logic r, input logic e, input logic [15:0] d);
        @(negedge clk);
        reset  = r;
        enable = e;
        d1     = d[0:0];
        d8     = d[7:0];
        d16    = d;
        if (!r) begin
            m1 = '0; m8 = '0; m16 = '0;
        end
        @(posedge clk);
        #1;
        if (r && e) begin
            m1 = d[0:0]; m8 = d[7:0]; m16 = d;
        end
    endtask

    // drop reset 3 time units after a rising edge, well before the next edge
    task automatic async_reset_pulse();
        #2;
        reset = 1'b0;
        m1 = '0; m8 = '0; m16 = '0;
        #1;
    endtask

    vec_t tbl[7];

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset  = 1'b0;
        enable = 1'b0;
        d1 = '0; d8 = '0; d16 = '0;
        m1 = '0; m8 = '0; m16 = '0;

        tbl[0] = '{1'b0, 1'b1, 8'hFF, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 8'hFF, 8'h00};
        tbl[2] = '{1'b0, 1'b1, 8'hFF, 8'h00};
        tbl[3] = '{1'b1, 1'b1, 8'hA5, 8'hA5};
        tbl[4] = '{1'b1, 1'b0, 8'h3C, 8'hA5};
        tbl[5] = '{1'b1, 1'b0, 8'h3C, 8'hA5};
        tbl[6] = '{1'b1, 1'b1, 8'h3C, 8'h3C};

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].rst, tbl[i].en, {8'h00, tbl[i].d});
            check($sformatf("table%0d", i), {8'd0, q8}, {8'd0, tbl[i].exp_q});
        end

        // async reset between edges: Q clears with no clock edge
        async_reset_pulse();
        check("async_clear_n8", {8'd0, q8}, 16'h0000);
        check_all("async_clear");

        // reset held low with enable high: stays cleared across edges
        step(1'b0, 1'b1, 16'hFFFF);
        check_all("reset_hold_a");
        step(1'b0, 1'b1, 16'hFFFF);
        check("reset_hold_n16", q16, 16'h0000);

        // post-reset reload, then hold with stable D
        step(1'b1, 1'b1, 16'h00FF);
        check("reload_n8", {8'd0, q8}, 16'h00FF);
        step(1'b1, 1'b1, 16'h00FF);
        check("reload_stable_n8", {8'd0, q8}, 16'h00FF);

        // back-to-back loads at all widths
        step(1'b1, 1'b1, 16'h0001);
        check("b2b1_n8", {8'd0, q8}, 16'h0001);
        check("b2b1_n1", {15'd0, q1}, 16'h0001);
        step(1'b1, 1'b1, 16'h0002);
        check("b2b2_n8", {8'd0, q8}, 16'h0002);
        check("b2b2_n1", {15'd0, q1}, 16'h0000);
        step(1'b1, 1'b1, 16'h8003);
        check("b2b3_n8", {8'd0, q8}, 16'h0003);
        check("b2b3_n16", q16, 16'h8003);
        check("b2b3_n1", {15'd0, q1}, 16'h0001);

        // enable pulsed between edges but low at the edge: no load
        @(negedge clk);
        enable = 1'b0;
        d1 = 1'b0; d8 = 8'h55; d16 = 16'h5555;
        #2 enable = 1'b1;
        #1 enable = 1'b0;
        @(posedge clk);
        #1;
        check("glitch_en_n8", {8'd0, q8}, 16'h0003);
        check_all("glitch_en");

        // randomized traffic with occasional mid-cycle reset pulses
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0,
                 $urandom_range(0, 1) != 0 ? 1'b1 : 1'b0,
                 16'($urandom));
            check_all($sformatf("rand%0d", i));
            if ($urandom_range(0, 19) == 0) begin
                async_reset_pulse();
                check_all($sformatf("rand_async%0d", i));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
